programmable_divider: RTL

Parametrised, runtime-programmable clock-enable and clock divider. It counts 0..N on CLK, with N held in an active divisor register. On each wrap it either toggles Qout (square wave, divide by 2(N+1)) or emits a one-cycle pulse (divide by N+1). New divisors are loaded through a shadow register and take effect only at a wrap, so the output never glitches. It sits between the system clock and slow peripherals (display scan, debounce, blinkers) and replaces fixed-ratio dividers.

---
 rtl/programmable_divider.sv | 107 ++++++++++
 1 files changed

// File: rtl/programmable_divider.sv
// programmable_divider
//    Runtime-programmable clock divider / clock-enable generator. A counter runs
//    0..N, where N is held in an active divisor register. On each wrap the
//    output either toggles (MODE=0, divide by 2(N+1)) or pulses for one cycle
//    (MODE=1, divide by N+1). A new divisor goes into a shadow register first
//    and is copied to the active register only at a wrap, so the counter never
//    has to jump and the output never glitches.
//
// Ports
//    CLK     in   clock, rising-edge active
//    RESET   in   asynchronous, active-high reset
//    EN      in   count enable; 0 freezes COUNT and Qout
//    LOAD    in   capture DIV into the shadow divisor on this edge
//    DIV     in   requested terminal count N (WIDTH bits)
//    MODE    in   0 = toggle output, 1 = pulse output
//    COUNT   out  current count value
//    Qout    out  divided output (registered)
//    TICK    out  registered one-cycle wrap pulse
//    PENDING out  shadow divisor loaded but not yet applied

module programmable_divider #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned RESET_DIV = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] DIV,
   input  logic             MODE,
   output logic [WIDTH-1:0] COUNT,
   output logic             Qout,
   output logic             TICK,
   output logic             PENDING
);

   localparam logic [WIDTH-1:0] ResetDiv = RESET_DIV[WIDTH-1:0];

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] div_active_q, div_active_d;
   logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
   logic             pending_q, pending_d;
   logic             qout_q, qout_d;
   logic             tick_q, tick_d;
   logic             wrap;

   always_comb begin
      count_d      = count_q;
      div_active_d = div_active_q;
      div_shadow_d = div_shadow_q;
      pending_d    = pending_q;
      qout_d       = qout_q;
      tick_d       = 1'b0;

      wrap = EN && (count_q == div_active_q);

      if (EN) begin
         if (wrap) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (pending_q) begin
               div_active_d = div_shadow_q;
               pending_d    = 1'b0;
            end
         end else begin
            count_d = count_q + 1'b1;
         end
      end

      if (MODE) begin
         qout_d = tick_d;
      end else if (wrap) begin
         qout_d = ~qout_q;
      end

      // A load on the applying wrap re-arms pending with the new value; the
      // old shadow has already been copied to the active register above.
      if (LOAD) begin
         div_shadow_d = DIV;
         pending_d    = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q      <= '0;
         div_active_q <= ResetDiv;
         div_shadow_q <= ResetDiv;
         pending_q    <= 1'b0;
         qout_q       <= 1'b0;
         tick_q       <= 1'b0;
      end else begin
         count_q      <= count_d;
         div_active_q <= div_active_d;
         div_shadow_q <= div_shadow_d;
         pending_q    <= pending_d;
         qout_q       <= qout_d;
         tick_q       <= tick_d;
      end
   end

   assign COUNT   = count_q;
   assign Qout    = qout_q;
   assign TICK    = tick_q;
   assign PENDING = pending_q;

endmodule
